// File: rtl/node_link_pkg.sv
// Shared types and constants for the node<->router byte-serial link.
package node_link_pkg;

    localparam int PKT_BYTES = 4;
    localparam int BYTE_W    = 8;

    typedef struct packed {
        logic [3:0]  source_id;
        logic [3:0]  dest_id;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_B1,
        TX_B2,
        TX_B3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_R1,
        RX_R2,
        RX_R3
    } rx_state_t;

    // First byte on the wire: source in the high nibble, destination in the low.
    function automatic logic [BYTE_W-1:0] hdr_byte(input pkt_t p);
        return {p.source_id, p.dest_id};
    endfunction

endpackage

// File: rtl/node_link_fifo.sv
// Packet FIFO for the TX queue; extra pointer MSB distinguishes full from empty.
module pkt_fifo
    import node_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic we,
    input  pkt_t wdata,
    input  logic re,
    output pkt_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    pkt_t        mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; writes into a full FIFO are ignored.
    always_ff @(posedge clk or posedge rst_b) begin
        // NOTE: reset is active-high here, so the sensitivity edge is posedge rst_b.
        if (rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (we && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (re && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (we && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/node_link.sv
// Node-side link endpoint: queued TX serializer and RX deserializer with valid/ack.
module node_link
    import node_link_pkg::*;
#(
    parameter int NODEID   = 0,
    parameter int TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  pkt_t              tx_pkt,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              free_in,
    output logic              put_out,
    output logic [BYTE_W-1:0] payload_out,
    input  logic              put_in,
    input  logic [BYTE_W-1:0] payload_in,
    output logic              free_out,
    output pkt_t              rx_pkt,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              tx_busy
);

    localparam logic [3:0] NODE_ID4 = 4'(NODEID);

    // ---------------- TX path ----------------
    pkt_t      enq_pkt;
    pkt_t      head_pkt;
    logic      fifo_full;
    logic      fifo_empty;
    logic      deq;
    tx_state_t tx_state;
    tx_state_t tx_nxt;
    logic [23:0] tx_data;

    // Stamp this node's ID into every packet as it enters the queue.
    always_comb begin
        enq_pkt           = tx_pkt;
        enq_pkt.source_id = NODE_ID4;
    end

    assign tx_ready = !fifo_full;

    pkt_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (tx_valid && tx_ready),
        .wdata (enq_pkt),
        .re    (deq),
        .rdata (head_pkt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX next state and wire outputs; byte0 goes out in the same cycle as the dequeue.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        tx_nxt      = tx_state;
        deq         = 1'b0;
        put_out     = 1'b0;
        payload_out = '0;
        tx_busy     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty && free_in) begin
                    deq         = 1'b1;
                    put_out     = 1'b1;
                    payload_out = hdr_byte(head_pkt);
                    tx_busy     = 1'b1;
                    tx_nxt      = TX_B1;
                end
            end
            TX_B1: begin
                put_out     = 1'b1;
                payload_out = tx_data[23:16];
                tx_busy     = 1'b1;
                tx_nxt      = TX_B2;
            end
            TX_B2: begin
                put_out     = 1'b1;
                payload_out = tx_data[15:8];
                tx_busy     = 1'b1;
                tx_nxt      = TX_B3;
            end
            TX_B3: begin
                // IDLE re-checks the queue combinationally, so a waiting packet
                // starts on the very next cycle without a gap.
                put_out     = 1'b1;
                payload_out = tx_data[7:0];
                tx_busy     = 1'b1;
                tx_nxt      = TX_IDLE;
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    // TX state register and payload holding register.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_nxt;
            if (deq)
                tx_data <= head_pkt.data;
        end
    end

    // ---------------- RX path ----------------
    rx_state_t   rx_state;
    rx_state_t   rx_nxt;
    logic        rx_done;
    logic [7:0]  rx_hdr;
    logic [7:0]  rx_hi;
    logic [7:0]  rx_mid;

    // RX next state; a gap mid-burst drops the partial packet.
    always_comb begin
        rx_nxt  = rx_state;
        rx_done = 1'b0;
        case (rx_state)
            RX_IDLE: if (put_in && free_out) rx_nxt = RX_R1;
            RX_R1:   rx_nxt = put_in ? RX_R2 : RX_IDLE;
            RX_R2:   rx_nxt = put_in ? RX_R3 : RX_IDLE;
            RX_R3: begin
                rx_done = put_in;
                rx_nxt  = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // RX state, byte capture, holding register and registered free flag.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rx_state <= RX_IDLE;
            rx_hdr   <= '0;
            rx_hi    <= '0;
            rx_mid   <= '0;
            rx_pkt   <= '0;
            rx_valid <= 1'b0;
            free_out <= 1'b1;
        end else begin
            rx_state <= rx_nxt;
            free_out <= !rx_valid || rx_ack;
            case (rx_state)
                RX_IDLE: if (put_in && free_out) rx_hdr <= payload_in;
                RX_R1:   if (put_in) rx_hi  <= payload_in;
                RX_R2:   if (put_in) rx_mid <= payload_in;
                default: ;
            endcase
            if (rx_done) begin
                rx_pkt   <= {rx_hdr, rx_hi, rx_mid, payload_in};
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/node_link.md
Name: node_link

Overview:
- Node-side endpoint of the node↔router byte-serial link; the counterpart of the router's per-port input/output buffers.
- TX path: accepts whole pkt_t packets from the node, queues them, and serializes each one onto the router's inbound link (put/payload with free flow control).
- RX path: deserializes 4-byte bursts from the router's outbound link into pkt_t and presents them to the node with a valid/ack handshake.
- One instance sits between each node and its router port.

Parameters:
- NODEID, 0: this node's ID; stamped into sourceID of every transmitted packet.
- TX_DEPTH, 4: TX packet FIFO depth in packets; power of 2, at least 2.

Ports:
- clk, input, 1: clock.
- rst_b, input, 1: reset, asynchronous, active-high.
- tx_pkt, input, 32 (pkt_t): packet from the node.
- tx_valid, input, 1: tx_pkt is valid this cycle.
- tx_ready, output, 1: TX FIFO not full; a packet is enqueued when tx_valid && tx_ready.
- free_in, input, 1: router input buffer can accept one whole packet.
- put_out, output, 1: payload_out byte is valid.
- payload_out, output, 8: serial byte to the router.
- put_in, input, 1: payload_in byte is valid.
- payload_in, input, 8: serial byte from the router.
- free_out, output, 1: node_link can accept one whole packet from the router.
- rx_pkt, output, 32 (pkt_t): assembled packet to the node.
- rx_valid, output, 1: rx_pkt holds an unconsumed packet.
- rx_ack, input, 1: node consumes rx_pkt; ignored when rx_valid=0.
- tx_busy, output, 1: TX serializer is mid-burst.

Behaviour:
- Reset (rst_b=1, asynchronous):
  - TX FIFO empty; TX FSM in IDLE; RX FSM in IDLE.
  - Outputs: put_out=0, payload_out=0, rx_valid=0, rx_pkt=0, tx_ready=1, free_out=1, tx_busy=0.
  - Reset mid-burst abandons the partial packet on either path; no partial output after release.
- Serial format, both directions: exactly 4 bytes on consecutive cycles with put=1 throughout.
  - byte0={sourceID[3:0],destID[3:0]}, byte1=data[23:16], byte2=data[15:8], byte3=data[7:0].
- TX FIFO:
  - Enqueue on tx_valid && tx_ready; sourceID is overwritten with NODEID[3:0] at enqueue.
  - Pointers are log2(TX_DEPTH)+1 bits; full when MSBs differ and the rest are equal.
  - Simultaneous enqueue and dequeue is permitted when full, but tx_ready is driven from registered full, so a full FIFO refuses enqueue that cycle.
- TX FSM, states IDLE, B1, B2, B3:
  - IDLE: if FIFO non-empty && free_in=1, dequeue head into the shift register, drive byte0 with put_out=1 in the same cycle, and go to B1.
  - B1→B2→B3: drive bytes 1..3 with put_out=1. free_in is ignored mid-burst; the router guarantees space for the whole packet.
  - B3: back-to-back is allowed. If FIFO non-empty && free_in=1, start the next packet's byte0 in the following cycle with no idle gap; otherwise return to IDLE.
  - put_out=0 and payload_out=0 whenever no byte is driven.
  - tx_busy=1 in B1..B3, and in IDLE during the byte0 cycle.
  - Latency: packet enqueued at cycle N into an empty FIFO, free_in=1 → byte0 at cycle N+1, byte3 at N+4.
- RX FSM, states IDLE, R1, R2, R3:
  - free_out = !rx_valid || rx_ack, registered: the holding register is empty or being drained.
  - IDLE: put_in=1 captures byte0 and goes to R1. R1..R3 capture bytes 1..3.
  - On byte3, rx_pkt is loaded and rx_valid=1 the next cycle.
  - put_in=0 mid-burst is a protocol error: return to IDLE, discard partial bytes, raise no valid.
  - rx_ack with rx_valid=1 clears rx_valid next cycle, unless a new packet completes that same cycle, in which case rx_valid stays 1 with the new rx_pkt.
  - put_in=1 in IDLE while free_out=0 is a router violation; the byte is dropped (assertion in the bench).
- TX and RX are fully independent; simultaneous activity never stalls either.

Decomposition:
- Shared package (existing): pkt_t {sourceID[3:0], destID[3:0], data[23:0]}, plus constants PKT_BYTES=4 and BYTE_W=8.
- Sub-module: pkt_fifo (parameterized depth, pkt_t data, we/re/full/empty), used for the TX queue.
- The serializer and deserializer FSMs stay inline.

Test Plan:
1. Reset, free_in=1, enqueue tx_pkt={src 9, dest 2, data 24'hABCDEF}, NODEID=5 → payload_out 8'h52, AB, CD, EF on cycles N+1..N+4 with put_out=1, then put_out=0.
2. Enqueue 5 packets back-to-back with free_in=0, TX_DEPTH=4 → tx_ready=0 after 4 accepted and put_out stays 0. Raise free_in → 16 consecutive put_out cycles carrying packets 1-4 in order, no gaps.
3. Drive put_in=1 with bytes 8'h31, 12, 34, 56 → rx_valid=1 with rx_pkt={src 3, dest 1, data 24'h123456} one cycle after the last byte, and free_out=0 until rx_ack.
4. rx_valid held, rx_ack pulsed in the same cycle a second burst's byte3 arrives → rx_valid stays 1 and rx_pkt updates to the second packet.
5. Drive put_in burst 8'h31, 12, then put_in=0 → no rx_valid. A following full burst 8'h40, 00, 00, 01 is received correctly.
6. Assert rst_b during TX B2 and during RX R2 → put_out=0 and rx_valid=0 immediately, FIFO empty, tx_ready=1. Normal traffic after release.
